// File: rtl/rv32_wb_pkg.sv
// Shared encodings for the MEM/WB writeback stage: result-source select,
// load width codes, FSM states and the captured-instruction record.
package rv32_wb_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  funct3;
    } wb_stage_t;

    // x0 is hardwired to zero, so a write to it is never issued.
    function automatic logic gpr_write_en(input logic regwrite, input logic [4:0] rd);
        return regwrite && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the byte/halfword lane of an aligned load word and sign- or
// zero-extends it according to the load funct3 code.
module load_extend
    import rv32_wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection then extension; unknown width codes read the whole word.
    always_comb begin
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   data = {{16{half_s[15]}}, half_s};
            F3_LBU:  data = {24'h00_0000, byte_s};
            F3_LHU:  data = {16'h0000, half_s};
            F3_LW:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB writeback stage: holds one instruction, waits for load data with a
// timeout, and issues a single registered GPR write per instruction.
module mem_wb_writeback
    import rv32_wb_pkg::*;
#(
    parameter int LD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_rd,
    input  logic [1:0]  mem_wb_sel,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_pc_plus4,
    input  logic [2:0]  mem_funct3,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        wb_flush,
    output logic        wb_stall,
    output logic [4:0]  rd_wb,
    output logic [31:0] rd_wb_data,
    output logic        RegWrite,
    output logic        load_err
);

    localparam int CNT_W = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    wb_stage_t        stage_q, stage_d;
    logic             regwrite_q, regwrite_d;
    logic [4:0]       rd_wb_q, rd_wb_d;
    logic [31:0]      rd_wb_data_q, rd_wb_data_d;
    logic             load_err_q, load_err_d;
    logic             capture_s;
    logic             timeout_s;
    logic [31:0]      ld_data_s;

    load_extend u_load_extend (
        .funct3 (stage_q.funct3),
        .offset (stage_q.alu[1:0]),
        .rdata  (dmem_rdata),
        .data   (ld_data_s)
    );

    // Stall drops the same cycle load data arrives so the next op can enter.
    assign wb_stall  = (state_q == S_WAIT) && !dmem_rvalid;
    assign capture_s = mem_valid && !wb_stall;
    assign timeout_s = (cnt_q == CNT_W'(LD_TIMEOUT - 1));

    assign RegWrite   = regwrite_q;
    assign rd_wb      = rd_wb_q;
    assign rd_wb_data = rd_wb_data_q;
    assign load_err   = load_err_q;

    // Next-state: retire the held instruction, then possibly capture a new one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        stage_d      = stage_q;
        regwrite_d   = 1'b0;
        rd_wb_d      = rd_wb_q;
        rd_wb_data_d = rd_wb_data_q;
        load_err_d   = 1'b0;

        if (state_q == S_WAIT) begin
            if (wb_flush) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
            end else if (dmem_rvalid) begin
                state_d      = S_IDLE;
                valid_d      = 1'b0;
                cnt_d        = {CNT_W{1'b0}};
                regwrite_d   = gpr_write_en(stage_q.regwrite, stage_q.rd);
                rd_wb_d      = stage_q.rd;
                rd_wb_data_d = ld_data_s;
            end else if (timeout_s) begin
                state_d    = S_IDLE;
                valid_d    = 1'b0;
                cnt_d      = {CNT_W{1'b0}};
                load_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (valid_q) begin
            valid_d = 1'b0;
            if (!wb_flush) begin
                regwrite_d   = gpr_write_en(stage_q.regwrite, stage_q.rd);
                rd_wb_d      = stage_q.rd;
                rd_wb_data_d = (stage_q.sel == WB_PC4) ? stage_q.pc4 : stage_q.alu;
            end else begin
                regwrite_d = 1'b0;
            end
        end else begin
            state_d = S_IDLE;
        end

        if (capture_s) begin
            valid_d          = 1'b1;
            stage_d.regwrite = mem_regwrite;
            stage_d.rd       = mem_rd;
            stage_d.sel      = mem_wb_sel;
            stage_d.alu      = mem_alu_result;
            stage_d.pc4      = mem_pc_plus4;
            stage_d.funct3   = mem_funct3;
            cnt_d            = {CNT_W{1'b0}};
            state_d          = (mem_wb_sel == WB_LOAD) ? S_WAIT : S_IDLE;
        end else begin
            stage_d = stage_q;
        end
    end

    // All stage state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            valid_q      <= 1'b0;
            stage_q      <= {$bits(wb_stage_t){1'b0}};
            regwrite_q   <= 1'b0;
            rd_wb_q      <= 5'd0;
            rd_wb_data_q <= 32'h0000_0000;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            stage_q      <= stage_d;
            regwrite_q   <= regwrite_d;
            rd_wb_q      <= rd_wb_d;
            rd_wb_data_q <= rd_wb_data_d;
            load_err_q   <= load_err_d;
        end
    end

endmodule

// File: doc/mem_wb_writeback.md
MEM_WB_WRITEBACK -- requirements
Module: mem_wb_writeback

Interface
REQ-001 SHALL have parameter LD_TIMEOUT, default 15: max cycles waiting for load data before abort.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port mem_valid  input  1  MEM-stage instruction present.
REQ-005 SHALL have port mem_regwrite  input  1  instruction writes a GPR.
REQ-006 SHALL have port mem_rd  input  5  destination register.
REQ-007 SHALL have port mem_wb_sel  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
REQ-008 SHALL have port mem_alu_result  input  32  ALU result / load address.
REQ-009 SHALL have port mem_pc_plus4  input  32  link value.
REQ-010 SHALL have port mem_funct3  input  3  load width/sign code.
REQ-011 SHALL have port dmem_rvalid  input  1  data memory read data valid.
REQ-012 SHALL have port dmem_rdata  input  32  aligned data-memory word.
REQ-013 SHALL have port wb_flush  input  1  kill instruction held in this stage.
REQ-014 SHALL have port wb_stall  output  1  upstream must hold MEM stage.
REQ-015 SHALL have ports rd_wb (5), rd_wb_data (32), RegWrite (1)  outputs  GPR write port.
REQ-016 SHALL have port load_err  output  1  one-cycle pulse on load timeout.

Function
REQ-017 SHALL capture MEM inputs in a stage register when mem_valid=1 and wb_stall=0; otherwise hold.
REQ-018 SHALL have FSM states IDLE and WAIT; IDLE->WAIT on capture of a load (mem_wb_sel=01); WAIT->IDLE on dmem_rvalid=1, on wb_flush=1, or on timeout.
REQ-019 SHALL drive wb_stall = (state==WAIT) && !dmem_rvalid, combinationally, so a new instruction is captured in the same cycle load data arrives.
REQ-020 SHALL, for captured non-load instructions, pulse RegWrite one cycle after capture (latency 1) with rd_wb_data = ALU result or PC+4.
REQ-021 SHALL, for loads, pulse RegWrite on the cycle after dmem_rvalid is sampled in WAIT, with extended load data.
REQ-022 SHALL extract load data by offset=alu_result[1:0]: LB/LBU byte lane offset, LH/LHU halfword lane offset[1] (bit 0 ignored), LW whole word; funct3 011/110/111 treated as LW.
REQ-023 SHALL sign-extend for LB (000)/LH (001) and zero-extend for LBU (100)/LHU (101).
REQ-024 SHALL hold RegWrite=0 whenever mem_regwrite=0 or rd=0; rd_wb/rd_wb_data still update.
REQ-025 SHALL count cycles in WAIT; when count reaches LD_TIMEOUT without dmem_rvalid, pulse load_err for one cycle, return to IDLE, suppress the write.
REQ-026 SHALL, on wb_flush, drop the held instruction with no write; flush takes priority over simultaneous dmem_rvalid or timeout.
REQ-027 SHALL keep RegWrite a single-cycle pulse; never two writes for one instruction.

Reset
REQ-028 SHALL on rst: state=IDLE, counter=0, RegWrite=0, load_err=0, rd_wb=0, rd_wb_data=0, stage register invalid; wb_stall=0.
REQ-029 SHALL abandon any pending load on rst mid-WAIT with no write and no load_err.

Structure
REQ-030 SHALL place wb_sel encodings, load funct3 constants, and FSM state encoding in shared package rv32_wb_pkg.
REQ-031 SHALL implement byte/halfword selection and extension in combinational sub-module load_extend.

Verification
REQ-032 ALU op rd=5, result 0x0000_1234 -> next cycle RegWrite=1, rd_wb=5, rd_wb_data=0x0000_1234.
REQ-033 LB addr offset 2, dmem_rdata=0x0080_0000, rvalid 3 cycles later -> wb_stall high 3 cycles, then rd_wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-034 LHU offset 2, rdata=0xBEEF_0000 -> 0x0000_BEEF; LH -> 0xFFFF_BEEF.
REQ-035 Load with no rvalid for 15 cycles -> load_err pulse, no RegWrite, wb_stall drops; rd=0 ALU op -> RegWrite stays 0.
REQ-036 wb_flush coincident with dmem_rvalid in WAIT -> no write; rst asserted mid-WAIT -> all outputs zero, next ALU op writes normally.
